// File: rtl/uart_key_decoder_pkg.sv
// Purpose: shared constants, FSM state type and byte-to-key decode helpers for the UART key
//          decoder. Key codes are one-hot so the consumer can test a single bit per action.
// Contents: KEY_* codes, ASCII_* constants, dec_state_e, decode_ascii(), decode_arrow().
package uart_key_decoder_pkg;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_UP    = 8'h01;
  localparam logic [7:0] KEY_DOWN  = 8'h02;
  localparam logic [7:0] KEY_RIGHT = 8'h04;
  localparam logic [7:0] KEY_LEFT  = 8'h08;
  localparam logic [7:0] KEY_TURBO = 8'h10;
  localparam logic [7:0] KEY_PAUSE = 8'h20;

  localparam logic [7:0] ASCII_ESC      = 8'h1B;
  localparam logic [7:0] ASCII_LBRACKET = 8'h5B;
  localparam logic [7:0] ASCII_SPACE    = 8'h20;

  // Idle: plain keys; Esc1: saw ESC; Esc2: saw ESC '['.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StEsc1 = 2'd1,
    StEsc2 = 2'd2
  } dec_state_e;

  // Plain ASCII keys, case-insensitive letters. Unmapped bytes give KEY_NONE.
  function automatic logic [7:0] decode_ascii(input logic [7:0] b);
    logic [7:0] code;
    unique case (b)
      8'h77, 8'h57: code = KEY_UP;     // w W
      8'h73, 8'h53: code = KEY_DOWN;   // s S
      8'h64, 8'h44: code = KEY_RIGHT;  // d D
      8'h61, 8'h41: code = KEY_LEFT;   // a A
      ASCII_SPACE:  code = KEY_TURBO;
      8'h70, 8'h50: code = KEY_PAUSE;  // p P
      default:      code = KEY_NONE;
    endcase
    return code;
  endfunction

  // Final byte of an ANSI arrow sequence ESC '[' {A,B,C,D}.
  function automatic logic [7:0] decode_arrow(input logic [7:0] b);
    logic [7:0] code;
    unique case (b)
      8'h41:   code = KEY_UP;
      8'h42:   code = KEY_DOWN;
      8'h43:   code = KEY_RIGHT;
      8'h44:   code = KEY_LEFT;
      default: code = KEY_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/uart_key_decoder_if.sv
// Purpose: bundles the RX FIFO read port and the decoded key outputs of the UART key decoder.
// Signals: r_data/rx_empty (FIFO head and empty flag), rd_uart (pop pulse),
//          key_data/key_strobe/turbo (decoded key word, update pulse, turbo toggle).
// Modports: master = FIFO/keyboard side, slave = decoder.
interface uart_key_decoder_if;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rd_uart;
  logic [7:0] key_data;
  logic       key_strobe;
  logic       turbo;

  modport master (
    output r_data,
    output rx_empty,
    input  rd_uart,
    input  key_data,
    input  key_strobe,
    input  turbo
  );

  modport slave (
    input  r_data,
    input  rx_empty,
    output rd_uart,
    output key_data,
    output key_strobe,
    output turbo
  );
endinterface

// File: rtl/uart_key_decoder_holdoff_timer.sv
// Purpose: loadable saturating down-counter. i_load reloads LOAD_VAL; otherwise the count
//          decrements each cycle and sticks at zero. o_expired is high while the count is zero,
//          so it is already high in the cycle the counter reaches zero.
// Ports: clk, rst (sync, active-low), i_load, o_expired.
module uart_key_decoder_holdoff_timer #(
  parameter int unsigned LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_expired
);

  // A zero load value still needs a 1-bit counter.
  localparam int unsigned Width = (LOAD_VAL > 0) ? $clog2(LOAD_VAL + 1) : 1;

  logic [Width-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= Width'(LOAD_VAL);
    end else if (r_count != '0) begin
      r_count <= r_count - Width'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/uart_key_decoder.sv
// Purpose: pops bytes from the UART RX FIFO, decodes WASD / space / 'p' and ANSI arrow
//          sequences into one-hot key codes, drops repeats of the same code within the holdoff
//          window and presents the result as a held key word plus a one-cycle strobe.
// Ports: clk, rst (sync, active-low), bus (uart_key_decoder_if.slave): r_data, rx_empty in;
//        rd_uart, key_data, key_strobe, turbo out.
// Timing: a byte popped in cycle N that is accepted shows key_strobe/key_data in N+1.
//         A repeat of the same code is accepted only more than HoldCycles cycles after the
//         previous accept. Inside an escape sequence the next byte must be popped at most
//         EscCycles cycles after the previous one, else the sequence is abandoned.
module uart_key_decoder
  import uart_key_decoder_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 65_000_000,
  parameter int unsigned HOLDOFF_MS     = 120,
  parameter int unsigned ESC_TIMEOUT_MS = 5
) (
  input logic               clk,
  input logic               rst,
  uart_key_decoder_if.slave bus
);

  localparam int unsigned HoldCycles = CLK_HZ / 1000 * HOLDOFF_MS;
  localparam int unsigned EscCycles  = CLK_HZ / 1000 * ESC_TIMEOUT_MS;
  // Escape timer expires EscCycles after the load, so a pop exactly then still counts.
  localparam int unsigned EscLoad    = (EscCycles > 0) ? EscCycles - 1 : 0;

  dec_state_e r_state;
  logic       r_pop_prev;
  logic [7:0] r_key_data;
  logic [7:0] r_last_code;
  logic       r_key_strobe;
  logic       r_turbo;

  logic       w_pop;
  logic       w_is_esc;
  logic [7:0] w_code;
  logic       w_accept;
  logic       w_esc_load;
  logic       w_esc_expired;
  logic       w_hold_expired;

  // Pop whenever data is waiting, but never in two consecutive cycles; gated by reset so
  // nothing is consumed while the block is held in reset.
  assign w_pop       = rst && !bus.rx_empty && !r_pop_prev;
  assign bus.rd_uart = w_pop;

  assign w_is_esc = (bus.r_data == ASCII_ESC);

  always_comb begin
    w_code     = KEY_NONE;
    w_esc_load = 1'b0;
    if (w_pop) begin
      if (w_is_esc) begin
        w_esc_load = 1'b1;
      end else begin
        unique case (r_state)
          StIdle:  w_code = decode_ascii(bus.r_data);
          StEsc1:  w_esc_load = (bus.r_data == ASCII_LBRACKET);
          StEsc2:  w_code = decode_arrow(bus.r_data);
          default: w_code = KEY_NONE;
        endcase
      end
    end
  end

  assign w_accept = (w_code != KEY_NONE) && ((w_code != r_last_code) || w_hold_expired);

  uart_key_decoder_holdoff_timer #(
    .LOAD_VAL (HoldCycles)
  ) u_holdoff (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_accept),
    .o_expired (w_hold_expired)
  );

  uart_key_decoder_holdoff_timer #(
    .LOAD_VAL (EscLoad)
  ) u_esc_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_esc_load),
    .o_expired (w_esc_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_pop_prev   <= 1'b0;
      r_key_data   <= KEY_NONE;
      r_last_code  <= KEY_NONE;
      r_key_strobe <= 1'b0;
      r_turbo      <= 1'b0;
    end else begin
      r_pop_prev   <= w_pop;
      r_key_strobe <= w_accept;

      if (w_accept) begin
        r_key_data  <= w_code;
        r_last_code <= w_code;
        if (w_code == KEY_TURBO) begin
          r_turbo <= !r_turbo;
        end
      end

      if (w_pop) begin
        if (w_is_esc) begin
          // ESC restarts a sequence from any state.
          r_state <= StEsc1;
        end else begin
          unique case (r_state)
            StEsc1:  r_state <= (bus.r_data == ASCII_LBRACKET) ? StEsc2 : StIdle;
            default: r_state <= StIdle;
          endcase
        end
      end else if ((r_state != StIdle) && w_esc_expired) begin
        r_state <= StIdle;
      end
    end
  end

  assign bus.key_data   = r_key_data;
  assign bus.key_strobe = r_key_strobe;
  assign bus.turbo      = r_turbo;

endmodule

// File: tb/tb_uart_key_decoder.sv
module tb_uart_key_decoder;

  localparam int HOLD = 10;  // 1000 Hz * 10 ms
  localparam int ESCT = 2;   // 1000 Hz * 2 ms

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_key_decoder_if u_if ();

  uart_key_decoder #(
    .CLK_HZ         (1000),
    .HOLDOFF_MS     (10),
    .ESC_TIMEOUT_MS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int checks = 0;
  int errors = 0;

  byte unsigned fifo[$];

  // Reference model state: how far into ESC '[' we are, when things last happened.
  int         cyc;
  int         esc_len;
  int         last_esc_byte;
  int         last_acc;
  logic [7:0] m_key;
  logic [7:0] m_last;
  logic       m_strobe;
  logic       m_turbo;
  logic       m_prev_pop;
  int         n_strobe;

  typedef struct {
    byte unsigned b;
    logic [7:0]   exp_key;
    int           exp_strobes;
  } vec_t;

  vec_t vecs[16];

  byte unsigned alphabet[16] = '{8'h77, 8'h73, 8'h64, 8'h61, 8'h57, 8'h20, 8'h70, 8'h1B,
                                 8'h5B, 8'h41, 8'h42, 8'h43, 8'h44, 8'h1B, 8'h5B, 8'h78};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] m_plain(input byte unsigned b);
    case (b)
      8'h77, 8'h57: return 8'h01;
      8'h73, 8'h53: return 8'h02;
      8'h64, 8'h44: return 8'h04;
      8'h61, 8'h41: return 8'h08;
      8'h20:        return 8'h10;
      8'h70, 8'h50: return 8'h20;
      default:      return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] m_arrow(input byte unsigned b);
    case (b)
      8'h41:   return 8'h01;
      8'h42:   return 8'h02;
      8'h43:   return 8'h04;
      8'h44:   return 8'h08;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    esc_len       = 0;
    last_esc_byte = -1000;
    last_acc      = -1000;
    m_key         = 8'h00;
    m_last        = 8'h00;
    m_strobe      = 1'b0;
    m_turbo       = 1'b0;
    m_prev_pop    = 1'b0;
  endtask

  task automatic model_byte(input byte unsigned b);
    logic [7:0] code;
    code = 8'h00;
    if (esc_len != 0 && cyc - last_esc_byte > ESCT) esc_len = 0;
    if (b == 8'h1B) begin
      esc_len       = 1;
      last_esc_byte = cyc;
    end else if (esc_len == 1) begin
      if (b == 8'h5B) begin
        esc_len       = 2;
        last_esc_byte = cyc;
      end else begin
        esc_len = 0;
      end
    end else if (esc_len == 2) begin
      code    = m_arrow(b);
      esc_len = 0;
    end else begin
      code = m_plain(b);
    end
    if (code != 8'h00 && (code != m_last || cyc - last_acc > HOLD)) begin
      m_key    = code;
      m_last   = code;
      last_acc = cyc;
      m_strobe = 1'b1;
      if (code == 8'h10) m_turbo = ~m_turbo;
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check the pop, advance model.
  task automatic step(input logic rst_v);
    logic exp_pop;
    @(negedge clk);
    chk("key_data", u_if.key_data, m_key);
    chk("key_strobe", u_if.key_strobe, m_strobe);
    chk("turbo", u_if.turbo, m_turbo);
    if (u_if.key_strobe === 1'b1) n_strobe++;
    rst           = rst_v;
    u_if.rx_empty = (fifo.size() == 0);
    u_if.r_data   = (fifo.size() != 0) ? fifo[0] : 8'h00;
    #1;
    exp_pop = rst_v && (fifo.size() != 0) && !m_prev_pop;
    chk("rd_uart", u_if.rd_uart, exp_pop);
    m_strobe = 1'b0;
    if (!rst_v) model_reset();
    else if (exp_pop) model_byte(fifo[0]);
    if (exp_pop) void'(fifo.pop_front());
    m_prev_pop = exp_pop;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b1);
  endtask

  task automatic do_reset();
    step(1'b0);
  endtask

  int base;

  initial begin
    vecs[0]  = '{8'h77, 8'h01, 1};
    vecs[1]  = '{8'h57, 8'h01, 1};
    vecs[2]  = '{8'h73, 8'h02, 1};
    vecs[3]  = '{8'h53, 8'h02, 1};
    vecs[4]  = '{8'h64, 8'h04, 1};
    vecs[5]  = '{8'h44, 8'h04, 1};
    vecs[6]  = '{8'h61, 8'h08, 1};
    vecs[7]  = '{8'h41, 8'h08, 1};
    vecs[8]  = '{8'h20, 8'h10, 1};
    vecs[9]  = '{8'h70, 8'h20, 1};
    vecs[10] = '{8'h50, 8'h20, 1};
    vecs[11] = '{8'h78, 8'h00, 0};
    vecs[12] = '{8'h42, 8'h00, 0};
    vecs[13] = '{8'h1B, 8'h00, 0};
    vecs[14] = '{8'h5B, 8'h00, 0};
    vecs[15] = '{8'h00, 8'h00, 0};

    u_if.rx_empty = 1'b1;
    u_if.r_data   = 8'h00;
    rst           = 1'b0;
    cyc           = 0;
    n_strobe      = 0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state plus rd_uart held low during reset even with data waiting.
    fifo.push_back(8'h77);
    do_reset();
    chk("rd_uart_in_reset", u_if.rd_uart, 1'b0);
    fifo.delete();
    run(2);

    // Single-byte decode table from a clean reset.
    for (int i = 0; i < 16; i++) begin
      do_reset();
      base = n_strobe;
      fifo.push_back(vecs[i].b);
      run(4);
      chk("tbl_key", u_if.key_data, vecs[i].exp_key);
      chk("tbl_strobes", n_strobe - base, vecs[i].exp_strobes);
    end

    // 1: single 'w'.
    do_reset();
    base = n_strobe;
    fifo.push_back(8'h77);
    run(4);
    chk("t1_strobes", n_strobe - base, 1);
    chk("t1_key", u_if.key_data, 8'h01);
    chk("t1_turbo", u_if.turbo, 1'b0);

    // 2: ESC [ C back to back, then a sequence with a 3-cycle gap before the final byte.
    do_reset();
    base = n_strobe;
    fifo.push_back(8'h1B); fifo.push_back(8'h5B); fifo.push_back(8'h43);
    run(8);
    chk("t2_strobes", n_strobe - base, 1);
    chk("t2_key", u_if.key_data, 8'h04);
    do_reset();
    base = n_strobe;
    fifo.push_back(8'h1B); fifo.push_back(8'h5B);
    run(5);
    fifo.push_back(8'h43);
    run(5);
    chk("t2_gap_strobes", n_strobe - base, 0);
    chk("t2_gap_key", u_if.key_data, 8'h00);

    // 3: holdoff. Repeat at +4 dropped, at +12 accepted.
    do_reset();
    base = n_strobe;
    fifo.push_back(8'h61);
    run(4);
    fifo.push_back(8'h61);
    run(8);
    fifo.push_back(8'h61);
    run(4);
    chk("t3_strobes", n_strobe - base, 2);
    chk("t3_key", u_if.key_data, 8'h08);
    // Repeat exactly HOLD cycles later is dropped.
    do_reset();
    base = n_strobe;
    fifo.push_back(8'h61);
    run(10);
    fifo.push_back(8'h61);
    run(4);
    chk("t3_edge10_strobes", n_strobe - base, 1);
    // Repeat HOLD+1 cycles later (counter just reached zero) is accepted.
    do_reset();
    base = n_strobe;
    fifo.push_back(8'h61);
    run(11);
    fifo.push_back(8'h61);
    run(4);
    chk("t3_edge11_strobes", n_strobe - base, 2);
    // Different code is never held off.
    do_reset();
    base = n_strobe;
    fifo.push_back(8'h61); fifo.push_back(8'h64);
    run(6);
    chk("t3_ad_strobes", n_strobe - base, 2);
    chk("t3_ad_key", u_if.key_data, 8'h04);

    // 4: turbo toggling.
    do_reset();
    fifo.push_back(8'h20);
    run(20);
    chk("t4_turbo1", u_if.turbo, 1'b1);
    chk("t4_key1", u_if.key_data, 8'h10);
    fifo.push_back(8'h77);
    run(20);
    chk("t4_turbo2", u_if.turbo, 1'b1);
    chk("t4_key2", u_if.key_data, 8'h01);
    fifo.push_back(8'h20);
    run(20);
    chk("t4_turbo3", u_if.turbo, 1'b0);
    chk("t4_key3", u_if.key_data, 8'h10);

    // 5: reset in the middle of ESC [ aborts it; 'B' then decodes as a plain (unmapped) byte.
    do_reset();
    fifo.push_back(8'h20);
    run(3);
    fifo.push_back(8'h1B); fifo.push_back(8'h5B);
    run(4);
    fifo.push_back(8'h42);
    do_reset();
    chk("t5_rd_in_reset", u_if.rd_uart, 1'b0);
    base = n_strobe;
    step(1'b1);
    chk("t5_key_after_rst", u_if.key_data, 8'h00);
    chk("t5_turbo_after_rst", u_if.turbo, 1'b0);
    chk("t5_strobe_after_rst", u_if.key_strobe, 1'b0);
    run(4);
    chk("t5_strobes", n_strobe - base, 0);
    chk("t5_key", u_if.key_data, 8'h00);

    // 6: back-to-back 'x','s'.
    do_reset();
    base = n_strobe;
    fifo.push_back(8'h78); fifo.push_back(8'h73);
    run(6);
    chk("t6_strobes", n_strobe - base, 1);
    chk("t6_key", u_if.key_data, 8'h02);

    // Randomised traffic against the model, with occasional resets.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset();
      end else begin
        int nb;
        nb = $urandom_range(1, 3);
        for (int k = 0; k < nb; k++) fifo.push_back(alphabet[$urandom_range(0, 15)]);
        run($urandom_range(0, 14));
      end
    end
    run(12);
    chk("rand_fifo_drained", fifo.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
